// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer FSM state encoding and datapath latency constants.
// FFT_BF_LAT is also used by the butterfly wrapper, so the write-back delay stays
// consistent with the real pipeline depth.
package fft_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } fft_state_e;

  // Butterfly latency: from enable-sampled operands to registered outputs.
  localparam int unsigned FFT_BF_LAT = 11;
  // Default data RAM / twiddle ROM read latency.
  localparam int unsigned FFT_RD_LAT = 1;

endpackage

// File: rtl/fft_wb_delay_line.sv
// Fixed-depth shift register carrying {tag, addr_x, addr_y} from issue to write-back.
// Shifts every cycle; a synchronous clear empties it so no pending write survives reset.
// Ports:
//   clk_i  - clock
//   clr_i  - synchronous clear, active-high
//   data_i - entry shifted in this cycle
//   data_o - entry leaving the line (Depth cycles after it entered)
module fft_wb_delay_line #(
  parameter int unsigned Depth = 12,
  parameter int unsigned Width = 13
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0][Width-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = data_i;
    for (int i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign data_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_butterfly_sequencer.sv
// Control-only scheduler for an in-place radix-2 DIT FFT. Issues one butterfly per cycle
// (operand addresses + twiddle index), drains the butterfly pipeline between stages so
// the next stage never reads a location before its last write, and writes results back
// to the operand addresses a fixed WB_DELAY cycles after each read.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start                - begin an FFT (only honoured in idle)
//   busy, done           - run in progress, one-cycle completion pulse
//   rd_en, rd_addr_x/y   - dual-port RAM read strobe and operand addresses
//   tw_addr              - twiddle ROM index k for W = exp(-j*2*pi*k/N)
//   bf_enable            - butterfly pipeline enable (equal to busy)
//   wr_en, wr_addr_x/y   - write-back strobe and addresses for out0/out1
//   stage                - current stage index
module fft_butterfly_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N    = 6,
  parameter int unsigned RD_LAT   = FFT_RD_LAT,
  parameter int unsigned BF_LAT   = FFT_BF_LAT,
  parameter int unsigned WB_DELAY = RD_LAT + BF_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG2N-1:0]           rd_addr_x,
  output logic [LOG2N-1:0]           rd_addr_y,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       bf_enable,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_x,
  output logic [LOG2N-1:0]           wr_addr_y,
  output logic [$clog2(LOG2N)-1:0]   stage
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned DW = (WB_DELAY > 1) ? $clog2(WB_DELAY) : 1;
  localparam int unsigned LW = 1 + 2 * LOG2N;

  localparam logic [KW-1:0]    KLast  = '1;  // N/2-1
  localparam logic [SW-1:0]    SLast  = SW'(LOG2N - 1);
  localparam logic [DW-1:0]    DLast  = DW'(WB_DELAY - 1);
  localparam logic [LOG2N-1:0] AddrOne = LOG2N'(1);
  localparam logic [SW-1:0]    TwMaxSh = SW'(KW);

  fft_state_e state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [KW-1:0]    k_q, k_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_x_q, rd_addr_x_d;
  logic [LOG2N-1:0] rd_addr_y_q, rd_addr_y_d;
  logic [KW-1:0]    tw_addr_q, tw_addr_d;

  logic [LOG2N-1:0] k_ext, half, j_idx, ax, ay;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StIssue: begin
        if (k_q == KLast) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDrain: begin
        if (drain_q == DLast) begin
          if (stage_q == SLast) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        stage_d = '0;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    // x = g*2*half + j equals k with its low s bits kept and the rest shifted up by one.
    k_ext = {1'b0, k_d};
    half  = AddrOne << stage_d;
    j_idx = k_ext & (half - AddrOne);
    ax    = ((k_ext & ~(half - AddrOne)) << 1) | j_idx;
    ay    = ax | half;

    rd_en_d     = (state_d == StIssue);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    rd_addr_x_d = rd_en_d ? ax : '0;
    rd_addr_y_d = rd_en_d ? ay : '0;
    tw_addr_d   = rd_en_d ? (j_idx[KW-1:0] << (TwMaxSh - stage_d)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      stage_q     <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_x_q <= '0;
      rd_addr_y_q <= '0;
      tw_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_x_q <= rd_addr_x_d;
      rd_addr_y_q <= rd_addr_y_d;
      tw_addr_q   <= tw_addr_d;
    end
  end

  // Write-back is timed purely by this tag line; the butterfly's own valid output
  // is also high for the dummy drain slots and must not be used.
  logic [LW-1:0] wb_in, wb_out;
  assign wb_in = {rd_en_q, rd_addr_x_q, rd_addr_y_q};

  fft_wb_delay_line #(
    .Depth(WB_DELAY),
    .Width(LW)
  ) u_wb_delay (
    .clk_i (clk),
    .clr_i (rst),
    .data_i(wb_in),
    .data_o(wb_out)
  );

  assign {wr_en, wr_addr_x, wr_addr_y} = wb_out;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_x = rd_addr_x_q;
  assign rd_addr_y = rd_addr_y_q;
  assign tw_addr   = tw_addr_q;
  assign bf_enable = busy_q;
  assign stage     = stage_q;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
module tb_fft_butterfly_sequencer;

  localparam int L3 = 3;
  localparam int L6 = 6;
  localparam int WB = 12;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start3 = 1'b0;
  logic start6 = 1'b0;

  always #5 clk = ~clk;

  // LOG2N=3 instance
  logic busy3, done3, rd_en3, bfe3, wr_en3;
  logic [L3-1:0] rx3, ry3, wx3, wy3;
  logic [L3-2:0] tw3;
  logic [1:0]    st3;

  // LOG2N=6 instance
  logic busy6, done6, rd_en6, bfe6, wr_en6;
  logic [L6-1:0] rx6, ry6, wx6, wy6;
  logic [L6-2:0] tw6;
  logic [2:0]    st6;

  fft_butterfly_sequencer #(.LOG2N(L3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .rd_en(rd_en3),
    .rd_addr_x(rx3), .rd_addr_y(ry3), .tw_addr(tw3), .bf_enable(bfe3), .wr_en(wr_en3),
    .wr_addr_x(wx3), .wr_addr_y(wy3), .stage(st3)
  );

  fft_butterfly_sequencer #(.LOG2N(L6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6), .rd_en(rd_en6),
    .rd_addr_x(rx6), .rd_addr_y(ry6), .tw_addr(tw6), .bf_enable(bfe6), .wr_en(wr_en6),
    .wr_addr_x(wx6), .wr_addr_y(wy6), .stage(st6)
  );

  logic [19:0] all3;
  assign all3 = {busy3, done3, rd_en3, rx3, ry3, tw3, bfe3, wr_en3, wx3, wy3, st3};

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int x; int y; int tw; int st; } rd_t;
  typedef struct { int cyc; int x; int y; } wr_t;
  typedef struct { int cyc; int x; int y; real r0; real i0; real r1; real i1; } bf_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  bf_t bf_q[$];

  real mem_re[64];
  real mem_im[64];

  function automatic int bitrev6(input int v);
    int r = 0;
    for (int b = 0; b < 6; b++) if (v[b]) r |= 1 << (5 - b);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all3 !== '0) begin
      errors++;
      $display("FAIL reset3_outputs: got %h, want 0", all3);
    end
    checks++;
    if ({busy6, done6, rd_en6, wr_en6, bfe6} !== 5'b0) begin
      errors++;
      $display("FAIL reset6_outputs: got %b, want 00000", {busy6, done6, rd_en6, wr_en6, bfe6});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full LOG2N=3 run, scoreboarding every read and write; optional stray start pulses.
  task automatic run_fft3(input bit inject);
    int cyc;
    int rd_cnt;
    bit exp_busy;
    rd_t r;
    wr_t w;
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < L3; s++) begin
      for (int k = 0; k < 4; k++) begin
        int half = 1 << s;
        r.cyc = 1 + s * (4 + WB) + k;
        r.x   = (k >> s) * 2 * half + (k % half);
        r.y   = r.x + half;
        r.tw  = ((k % half) << (L3 - 1 - s)) & 3;
        r.st  = s;
        rd_q.push_back(r);
        w.cyc = r.cyc + WB;
        w.x   = r.x;
        w.y   = r.y;
        wr_q.push_back(w);
      end
    end
    rd_cnt = 0;
    @(negedge clk);
    start3 = 1'b1;
    cyc = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      cyc++;
      start3 = inject && (cyc == 10 || cyc == 30);
      exp_busy = (cyc >= 1 && cyc <= 49);
      checks++;
      if (busy3 !== exp_busy) begin
        errors++;
        $display("FAIL busy3 cyc %0d: got %b, want %b", cyc, busy3, exp_busy);
      end
      checks++;
      if (bfe3 !== exp_busy) begin
        errors++;
        $display("FAIL bf_enable3 cyc %0d: got %b, want %b", cyc, bfe3, exp_busy);
      end
      checks++;
      if (done3 !== (cyc == 49)) begin
        errors++;
        $display("FAIL done3 cyc %0d: got %b, want %b", cyc, done3, (cyc == 49));
      end
      if (rd_en3) begin
        rd_cnt++;
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd3_unexpected cyc %0d: got rd_en=1, want 0", cyc);
        end else begin
          r = rd_q.pop_front();
          if (r.cyc !== cyc || int'(rx3) !== r.x || int'(ry3) !== r.y ||
              int'(tw3) !== r.tw || int'(st3) !== r.st) begin
            errors++;
            $display("FAIL rd3 cyc %0d: got (x%0d y%0d tw%0d st%0d), want cyc %0d (x%0d y%0d tw%0d st%0d)",
                     cyc, rx3, ry3, tw3, st3, r.cyc, r.x, r.y, r.tw, r.st);
          end
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        checks++;
        errors++;
        $display("FAIL rd3_missing cyc %0d: got rd_en=0, want 1", cyc);
        void'(rd_q.pop_front());
      end
      if (wr_en3) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr3_unexpected cyc %0d: got wr_en=1, want 0", cyc);
        end else begin
          w = wr_q.pop_front();
          if (w.cyc !== cyc || int'(wx3) !== w.x || int'(wy3) !== w.y) begin
            errors++;
            $display("FAIL wr3 cyc %0d: got (x%0d y%0d), want cyc %0d (x%0d y%0d)",
                     cyc, wx3, wy3, w.cyc, w.x, w.y);
          end
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        checks++;
        errors++;
        $display("FAIL wr3_missing cyc %0d: got wr_en=0, want 1", cyc);
        void'(wr_q.pop_front());
      end
    end
    start3 = 1'b0;
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL fft3_leftover: got %0d rd / %0d wr pending, want 0 / 0",
               rd_q.size(), wr_q.size());
    end
    checks++;
    if (rd_cnt !== 12) begin
      errors++;
      $display("FAIL rd3_count: got %0d, want 12", rd_cnt);
    end
  endtask

  task automatic test_stage_sequence();
    run_fft3(1'b0);
  endtask

  task automatic test_start_ignored();
    run_fft3(1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (17) @(negedge clk);  // into stage-1 issue
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (all3 !== '0) begin
        errors++;
        $display("FAIL reset_mid edge %0d: got %h, want 0", i, all3);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy3, wr_en3, rd_en3} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle cyc %0d: got %b, want 000", i, {busy3, wr_en3, rd_en3});
      end
    end
  endtask

  task automatic test_start_with_rst();
    @(negedge clk);
    rst = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start3 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy3 !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst: got busy=%b, want 0", busy3);
    end
  endtask

  task automatic test_back_to_back();
    run_fft3(1'b0);
    run_fft3(1'b0);
  endtask

  // LOG2N=6 with a RAM + butterfly model; input is a shifted impulse x[n]=delta(n-pos).
  task automatic test_fft64(input int pos);
    int cyc;
    int done_cyc;
    int done_cnt;
    bf_t b;
    real a, wr, wi, xr, xi, yr, yi, pr, pi_;
    for (int i = 0; i < 64; i++) begin
      mem_re[i] = 0.0;
      mem_im[i] = 0.0;
    end
    mem_re[bitrev6(pos)] = 1.0;
    bf_q.delete();
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    start6 = 1'b1;
    cyc = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      cyc++;
      start6 = 1'b0;
      if (done6) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (wr_en6) begin
        checks++;
        if (bf_q.size() == 0) begin
          errors++;
          $display("FAIL wr6_unexpected cyc %0d: got wr_en=1, want 0", cyc);
        end else begin
          b = bf_q.pop_front();
          if (b.cyc !== cyc || int'(wx6) !== b.x || int'(wy6) !== b.y) begin
            errors++;
            $display("FAIL wr6 cyc %0d: got (x%0d y%0d), want cyc %0d (x%0d y%0d)",
                     cyc, wx6, wy6, b.cyc, b.x, b.y);
          end
          mem_re[wx6] = b.r0;
          mem_im[wx6] = b.i0;
          mem_re[wy6] = b.r1;
          mem_im[wy6] = b.i1;
        end
      end
      if (rd_en6) begin
        a  = -2.0 * PI * real'(int'(tw6)) / 64.0;
        wr = $cos(a);
        wi = $sin(a);
        xr = mem_re[rx6];
        xi = mem_im[rx6];
        yr = mem_re[ry6];
        yi = mem_im[ry6];
        pr = wr * yr - wi * yi;
        pi_ = wr * yi + wi * yr;
        b.cyc = cyc + WB;
        b.x = int'(rx6);
        b.y = int'(ry6);
        b.r0 = xr + pr;
        b.i0 = xi + pi_;
        b.r1 = xr - pr;
        b.i1 = xi - pi_;
        bf_q.push_back(b);
      end
    end
    checks++;
    if (done_cyc !== 265 || done_cnt !== 1) begin
      errors++;
      $display("FAIL done6: got cyc %0d count %0d, want cyc 265 count 1", done_cyc, done_cnt);
    end
    checks++;
    if (bf_q.size() != 0) begin
      errors++;
      $display("FAIL wr6_leftover: got %0d pending, want 0", bf_q.size());
    end
    for (int k = 0; k < 64; k++) begin
      int gr, gi, er, ei;
      a  = -2.0 * PI * real'((k * pos) % 64) / 64.0;
      er = int'($cos(a) * 1000.0);
      ei = int'($sin(a) * 1000.0);
      gr = int'(mem_re[k] * 1000.0);
      gi = int'(mem_im[k] * 1000.0);
      checks++;
      if (gr !== er || gi !== ei) begin
        errors++;
        $display("FAIL fft64 pos %0d bin %0d: got (%0d,%0d)/1000, want (%0d,%0d)/1000",
                 pos, k, gr, gi, er, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stage_sequence();
    test_start_ignored();
    test_reset_mid();
    test_start_with_rst();
    test_back_to_back();
    test_fft64(0);
    test_fft64(1);
    test_fft64(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
